keyvalue_store_p: RTL and testbench

Parametrised successor to the fixed-size key-value stores: a small associative store with configurable key width, data width and depth. Supports GET, PUT (insert or update), DELETE and CLEAR through a single-outstanding STB/CYC/ACK slave handshake. Lookup is a sequential linear scan, one entry per cycle. Reports hit, error, occupancy and a debug word for the logic analyser. Sits behind the Wishbone address/data split used by the top-level wrapper, with the key driven from the low address bits.

---
 rtl/keyvalue_store_p.sv | 162 ++++++++++++++++
 tb/tb_keyvalue_store_p.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keyvalue_store_p.sv
// rtl/keyvalue_store_p.sv - parametrised associative key-value store
// Linear-scan lookup over flop storage behind a single-outstanding STB/CYC/ACK slave.
module keyvalue_store_p #(
  parameter int KEY_W  = 64,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              STB_i,
  input  logic              CYC_i,
  input  logic              WE_i,
  input  logic [1:0]        OP_i,
  input  logic [KEY_W-1:0]  KEY_i,
  input  logic [DATA_W-1:0] DAT_i,
  output logic [DATA_W-1:0] DAT_o,
  output logic              ACK_o,
  output logic              HIT_o,
  output logic              ERR_o,
  output logic              FULL_o,
  output logic [CNT_W-1:0]  COUNT_o,
  output logic [31:0]       LA_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;

  logic [KEY_W-1:0]  key_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [1:0]        op_q;
  logic              we_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q, match_idx, free_idx;
  logic              free_found, hit_q, err_q;

  logic accept, entry_match, idx_last, is_get, is_put, is_del;

  assign accept      = STB_i && CYC_i && !ACK_o;
  assign entry_match = valid_q[idx_q] && (key_mem[idx_q] == key_q);
  assign idx_last    = (idx_q == IDX_W'(DEPTH - 1));
  // Reserved opcode 11 behaves as a GET.
  assign is_get      = ((op_q == 2'b00) && !we_q) || (op_q == 2'b11);
  assign is_put      = (op_q == 2'b00) && we_q;
  assign is_del      = (op_q == 2'b01);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (OP_i == 2'b10) ? DONE : SCAN;
      SCAN:  if (entry_match || idx_last) state_d = WRITE;
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q    <= '0;
      op_q       <= '0;
      we_q       <= 1'b0;
      key_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      match_idx  <= '0;
      free_idx   <= '0;
      free_found <= 1'b0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      DAT_o      <= '0;
      ACK_o      <= 1'b0;
      HIT_o      <= 1'b0;
      ERR_o      <= 1'b0;
      FULL_o     <= 1'b0;
      COUNT_o    <= '0;
    end else begin
      ACK_o <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q       <= OP_i;
          we_q       <= WE_i;
          key_q      <= KEY_i;
          data_q     <= DAT_i;
          idx_q      <= '0;
          free_found <= 1'b0;
          hit_q      <= 1'b0;
          err_q      <= 1'b0;
        end
        SCAN: begin
          if (!valid_q[idx_q] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx_q;
          end
          if (entry_match) begin
            hit_q     <= 1'b1;
            match_idx <= idx_q;
          end else if (!idx_last) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WRITE: begin
          if (is_get) DAT_o <= hit_q ? data_mem[match_idx] : '0;
          if (is_put && !hit_q) begin
            // No free slot seen during the scan means the store is full.
            if (free_found) begin
              valid_q[free_idx] <= 1'b1;
              COUNT_o           <= COUNT_o + 1'b1;
              FULL_o            <= (COUNT_o + 1'b1 == CNT_W'(DEPTH));
            end else begin
              err_q <= 1'b1;
            end
          end
          if (is_del && hit_q) begin
            valid_q[match_idx] <= 1'b0;
            COUNT_o            <= COUNT_o - 1'b1;
            FULL_o             <= 1'b0;
          end
        end
        DONE: begin
          ACK_o <= 1'b1;
          HIT_o <= hit_q;
          ERR_o <= err_q;
          if (op_q == 2'b10) begin
            valid_q <= '0;
            COUNT_o <= '0;
            FULL_o  <= 1'b0;
            HIT_o   <= 1'b0;
            ERR_o   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Arrays are not reset; the async reset only stops a write by leaving WRITE.
  always_ff @(posedge sys_clk) begin
    if (state_q == WRITE && is_put) begin
      if (hit_q) begin
        data_mem[match_idx] <= data_q;
      end else if (free_found) begin
        key_mem[free_idx]  <= key_q;
        data_mem[free_idx] <= data_q;
      end
    end
  end

  assign LA_o = {state_q, 8'(idx_q), 8'(COUNT_o), 14'b0};

endmodule

// File: tb/tb_keyvalue_store_p.sv
// tb/tb_keyvalue_store_p.sv - scoreboard bench for keyvalue_store_p
module tb_keyvalue_store_p;

  localparam int KEY_W  = 64;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              STB_i = 1'b0, CYC_i = 1'b0, WE_i = 1'b0;
  logic [1:0]        OP_i = 2'b00;
  logic [KEY_W-1:0]  KEY_i = '0;
  logic [DATA_W-1:0] DAT_i = '0;
  logic [DATA_W-1:0] DAT_o;
  logic              ACK_o, HIT_o, ERR_o, FULL_o;
  logic [CNT_W-1:0]  COUNT_o;
  logic [31:0]       LA_o;

  keyvalue_store_p #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .STB_i(STB_i), .CYC_i(CYC_i),
    .WE_i(WE_i), .OP_i(OP_i), .KEY_i(KEY_i), .DAT_i(DAT_i), .DAT_o(DAT_o),
    .ACK_o(ACK_o), .HIT_o(HIT_o), .ERR_o(ERR_o), .FULL_o(FULL_o),
    .COUNT_o(COUNT_o), .LA_o(LA_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int                cyc;
    logic              hit;
    logic              err;
    logic [DATA_W-1:0] dat;
    int                cnt;
    logic              full;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic              m_valid [DEPTH];
  logic [KEY_W-1:0]  m_key   [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];
  int                m_count = 0;
  logic [DATA_W-1:0] m_dat_o = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_count = 0;
    m_dat_o = '0;
  endtask

  // Reference behaviour: op 0=GET 1=PUT 2=DELETE 3=CLEAR
  task automatic model_op(input int op, input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] dat);
    exp_t e;
    int mi, fi;
    mi = -1; fi = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mi < 0 && m_valid[i] && m_key[i] == key) mi = i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (fi < 0 && !m_valid[i] && (mi < 0 || i < mi)) fi = i;
    end
    e.hit = (mi >= 0);
    e.err = 1'b0;
    e.cyc = (mi >= 0) ? mi + 3 : DEPTH + 2;
    case (op)
      0: m_dat_o = (mi >= 0) ? m_data[mi] : '0;
      1: begin
        if (mi >= 0) m_data[mi] = dat;
        else if (fi >= 0) begin
          m_valid[fi] = 1'b1; m_key[fi] = key; m_data[fi] = dat; m_count++;
        end else e.err = 1'b1;
      end
      2: if (mi >= 0) begin m_valid[mi] = 1'b0; m_count--; end
      default: begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_count = 0; e.hit = 1'b0; e.cyc = 1;
      end
    endcase
    e.dat  = m_dat_o;
    e.cnt  = m_count;
    e.full = (m_count == DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic do_op(input int op, input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] dat);
    exp_t e;
    int cyc;
    model_op(op, key, dat);
    @(negedge sys_clk);
    STB_i = 1'b1; CYC_i = 1'b1;
    WE_i  = (op == 1);
    OP_i  = (op == 2) ? 2'b01 : (op == 3) ? 2'b10 : 2'b00;
    KEY_i = key; DAT_i = dat;
    @(posedge sys_clk);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge sys_clk);
      if (cyc == 0) begin
        // Inputs after accept must be ignored.
        STB_i = 1'b0; CYC_i = 1'b0; KEY_i = ~key; DAT_i = ~dat; WE_i = ~WE_i;
      end
      if (ACK_o) break;
      cyc++;
    end
    e = exp_q.pop_front();
    check("ack_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
    check("hit", DATA_W'(HIT_o), DATA_W'(e.hit));
    check("err", DATA_W'(ERR_o), DATA_W'(e.err));
    check("dat", DAT_o, e.dat);
    check("count", DATA_W'(COUNT_o), DATA_W'(e.cnt));
    check("full", DATA_W'(FULL_o), DATA_W'(e.full));
  endtask

  initial begin
    int saw_ack;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_ack", DATA_W'(ACK_o), 0);
    check("rst_hit", DATA_W'(HIT_o), 0);
    check("rst_err", DATA_W'(ERR_o), 0);
    check("rst_dat", DAT_o, 0);
    check("rst_count", DATA_W'(COUNT_o), 0);
    check("rst_full", DATA_W'(FULL_o), 0);
    check("rst_la", DATA_W'(LA_o), 0);

    do_op(0, 64'h1234, '0);
    do_op(1, 64'hA, 128'hDEAD);
    do_op(0, 64'hA, '0);
    do_op(1, 64'hA, 128'hBEEF);
    do_op(0, 64'hA, '0);

    for (int i = 1; i < DEPTH; i++) do_op(1, 64'h100 + 64'(i), 128'h5000 + 128'(i));
    do_op(1, 64'h999, 128'h9999);
    do_op(0, 64'h999, '0);
    do_op(0, 64'h10F, '0);

    do_op(2, 64'h103, '0);
    do_op(2, 64'h103, '0);
    do_op(1, 64'h777, 128'h7777);
    do_op(0, 64'h777, '0);
    do_op(3, 64'h0, '0);
    do_op(0, 64'h10A, '0);
    do_op(0, 64'hA, '0);
    do_op(0, 64'h777, '0);

    do_op(1, 64'h21, 128'h21);
    do_op(1, 64'h22, 128'h22);

    @(negedge sys_clk);
    STB_i = 1'b1; CYC_i = 1'b1; WE_i = 1'b1; OP_i = 2'b00; KEY_i = 64'h33; DAT_i = 128'h33;
    @(posedge sys_clk);
    @(negedge sys_clk);
    STB_i = 1'b0; CYC_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("la_scan", DATA_W'(LA_o), DATA_W'({2'b01, 8'd3, 8'd2, 14'b0}));
    sys_rst_n = 1'b0;
    model_reset();
    saw_ack = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      if (i == 2) sys_rst_n = 1'b1;
      if (ACK_o) saw_ack = 1;
    end
    check("abort_no_ack", DATA_W'(saw_ack), 0);
    check("abort_count", DATA_W'(COUNT_o), 0);
    do_op(0, 64'h33, '0);
    do_op(0, 64'h21, '0);

    check("queue_empty", DATA_W'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
